regfile_wb_sched: RTL and testbench

Write-port scheduler and scoreboard for the single-write-port integer register file.
- Arbitrates NUM_REQ writeback sources (ALU, load unit, CSR/mul) onto the one write port through a registered output stage.
- Tracks pending destination registers. Tells issue/decode when a source operand is not yet available, and refuses issue to a register that already has a pending write.
- Sits between the execute/memory stages and the register file write port, and beside decode.

---
 rtl/regfile_wb_sched_pkg.sv | 11 +
 rtl/regfile_wb_sched_arbiter.sv | 36 +++
 rtl/regfile_wb_sched.sv | 89 ++++++++
 tb/tb_regfile_wb_sched.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_sched_pkg.sv
// regfile_wb_sched_pkg: shared register-file constants used by the writeback scheduler.
package regfile_wb_sched_pkg;
    localparam logic RstEnable = 1'b1;
    localparam logic RstDisable = 1'b0;
    localparam logic WriteEnable = 1'b1;
    localparam int RegAddrBus = 5;
    localparam int RegBus = 32;
    localparam int RegNum = 32;
    localparam int RegNumLog2 = 5;
    localparam logic [RegBus-1:0] ZeroWord = '0;
endpackage

// File: rtl/regfile_wb_sched_arbiter.sv
// wb_arbiter: one-hot grant over the writeback requesters.
// WB_SCHED_RR_EN selects round-robin from rr_ptr; otherwise lowest index wins.
module wb_arbiter #(
    parameter int N = 3
) (
`ifdef WB_SCHED_RR_EN
    input  logic         clk,
    input  logic         rst,
`endif
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);
`ifdef WB_SCHED_RR_EN
    localparam int PW = N > 1 ? $clog2(N) : 1;
    logic [PW-1:0] rr_ptr, ptr_nxt;
    always_comb begin
        int idx;
        logic found;
        grant = '0;
        ptr_nxt = rr_ptr;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(rr_ptr) + k) % N;
            if (!found && req[idx]) begin
                found = 1'b1;
                grant[idx] = 1'b1;
                ptr_nxt = PW'((idx + 1) % N);
            end
        end
    end
    always_ff @(posedge clk) rr_ptr <= rst ? '0 : ptr_nxt;
`else
    // isolate the lowest set bit
    assign grant = req & (~req + 1'b1);
`endif
endmodule

// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched: single write-port scheduler plus pending-destination scoreboard.
// Define WB_SCHED_RR_EN for round-robin arbitration (default: fixed priority).
module regfile_wb_sched
    import regfile_wb_sched_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W = RegAddrBus,
    parameter int DATA_W = RegBus,
    parameter int REG_NUM = RegNum
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      iss_valid,
    input  logic [ADDR_W-1:0]         iss_rd,
    output logic                      iss_ready,
    input  logic [ADDR_W-1:0]         chk_raddr1,
    input  logic [ADDR_W-1:0]         chk_raddr2,
    output logic                      chk_stall,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      we,
    output logic [ADDR_W-1:0]         waddr,
    output logic [DATA_W-1:0]         wdata
);
    logic [NUM_REQ-1:0] grant;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_data;
    logic [REG_NUM-1:0] busy, busy_nxt;
    logic set_busy;

    wb_arbiter #(.N(NUM_REQ)) u_arb (
`ifdef WB_SCHED_RR_EN
        .clk(clk),
        .rst(rst),
`endif
        .req(req_valid & {NUM_REQ{rst == RstDisable}}),
        .grant(grant)
    );

    assign req_ready = grant;

    always_comb begin
        g_addr = '0;
        g_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                g_addr = req_addr[i*ADDR_W +: ADDR_W];
                g_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            we <= ~WriteEnable;
            waddr <= '0;
            wdata <= DATA_W'(ZeroWord);
        end else begin
            we <= (|grant && g_addr != '0) ? WriteEnable : ~WriteEnable;
            if (|grant) begin
                waddr <= g_addr;
                wdata <= g_data;
            end
        end
    end

    assign set_busy = iss_valid && iss_ready && iss_rd != '0;

    // the set is applied after the clear so a new producer wins on the same edge
    always_comb begin
        busy_nxt = busy;
        if (we) busy_nxt[waddr] = 1'b0;
        if (set_busy) busy_nxt[iss_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) busy <= (rst == RstEnable) ? '0 : busy_nxt;

    assign iss_ready = rst == RstDisable && (iss_rd == '0 || !busy[iss_rd] || (we && waddr == iss_rd));

    // a register written this cycle is forwarded by the register file, so it does not stall
    function automatic logic pend(input logic [ADDR_W-1:0] a);
        return a != '0 && busy[a] && !(we && waddr == a);
    endfunction

    assign chk_stall = pend(chk_raddr1) || pend(chk_raddr2);
endmodule

// File: tb/tb_regfile_wb_sched.sv
// tb_regfile_wb_sched: directed and random stimulus against a reference model of the scheduler.
module tb_regfile_wb_sched;
    localparam int N = 3;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int RN = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic iss_valid = 1'b0;
    logic [AW-1:0] iss_rd = '0, chk_raddr1 = '0, chk_raddr2 = '0;
    logic [N-1:0] req_valid = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_data = '0;
    logic iss_ready, chk_stall, we;
    logic [N-1:0] req_ready;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;

    int tests = 0;
    int fails = 0;

    bit mbusy[RN];
    bit mwe;
    logic [AW-1:0] mwaddr;
    logic [DW-1:0] mwdata;
    int mptr = 0;
    bit pv[N];
    logic [AW-1:0] pa[N];
    logic [DW-1:0] pd[N];

    regfile_wb_sched dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .chk_raddr1(chk_raddr1), .chk_raddr2(chk_raddr2), .chk_stall(chk_stall),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
        .we(we), .waddr(waddr), .wdata(wdata)
    );

    always #50 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick();
        int idx;
        if (rst) return -1;
        for (int k = 0; k < N; k++) begin
            idx = (mptr + k) % N;
            if (pv[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic bit stall_of(input logic [AW-1:0] a);
        return a != 0 && mbusy[a] && !(mwe && mwaddr == a);
    endfunction

    // one clock: starts and ends at a falling edge
    task automatic cycle();
        int g;
        bit ir;
        for (int i = 0; i < N; i++) begin
            req_valid[i] = pv[i];
            req_addr[i*AW +: AW] = pa[i];
            req_data[i*DW +: DW] = pd[i];
        end
        #1;
        g = pick();
        ir = !rst && (iss_rd == 0 || !mbusy[iss_rd] || (mwe && mwaddr == iss_rd));
        chk("req_ready", 32'(req_ready), g < 0 ? 32'd0 : 32'd1 << g);
        chk("iss_ready", 32'(iss_ready), 32'(ir));
        chk("chk_stall", 32'(chk_stall), 32'(stall_of(chk_raddr1) || stall_of(chk_raddr2)));
        @(posedge clk);
        if (rst) begin
            for (int r = 0; r < RN; r++) mbusy[r] = 0;
            mwe = 0;
            mwaddr = '0;
            mwdata = '0;
            mptr = 0;
        end else begin
            if (mwe) mbusy[mwaddr] = 0;
            if (iss_valid && ir && iss_rd != 0) mbusy[iss_rd] = 1;
            mwe = g >= 0 && pa[g] != 0;
            if (g >= 0) begin
                mwaddr = pa[g];
                mwdata = pd[g];
                pv[g] = 0;
`ifdef WB_SCHED_RR_EN
                mptr = (g + 1) % N;
`endif
            end
        end
        #1;
        chk("we", 32'(we), 32'(mwe));
        chk("waddr", 32'(waddr), 32'(mwaddr));
        chk("wdata", wdata, mwdata);
        @(negedge clk);
    endtask

    // sweep every register through a read port to observe the scoreboard
    task automatic probe();
        chk_raddr2 = '0;
        for (int r = 0; r < RN; r++) begin
            chk_raddr1 = AW'(r);
            #1;
            chk("busy_probe", 32'(chk_stall), 32'(stall_of(AW'(r))));
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            pv[i] = 1;
            pa[i] = AW'(i + 1);
            pd[i] = $urandom;
        end
        cycle();
        cycle();
        probe();
        rst = 0;
        cycle();
        cycle();
        cycle();
        iss_valid = 1; iss_rd = 5;
        cycle();
        iss_valid = 0; chk_raddr1 = 5;
        pv[1] = 1; pa[1] = 5; pd[1] = 32'hDEAD_BEEF;
        cycle();
        cycle();
        chk("single_wdata", wdata, 32'hDEAD_BEEF);
        cycle();
        probe();
        iss_valid = 1; iss_rd = 0;
        cycle();
        iss_valid = 0;
        pv[0] = 1; pa[0] = 0; pd[0] = 32'd1;
        cycle();
        cycle();
        chk("x0_we", 32'(we), 32'd0);
        iss_valid = 1; iss_rd = 7; chk_raddr1 = 7;
        cycle();
        cycle();
        pv[2] = 1; pa[2] = 7; pd[2] = $urandom;
        cycle();
        cycle();
        iss_valid = 0;
        probe();
        iss_valid = 1; iss_rd = 9;
        cycle();
        iss_valid = 0;
        pv[0] = 1; pa[0] = 9; pd[0] = $urandom;
        cycle();
        rst = 1;
        cycle();
        rst = 0;
        probe();
        for (int i = 0; i < N; i++) begin
            pv[i] = 1;
            pa[i] = AW'(i + 10);
            pd[i] = $urandom;
        end
        for (int c = 0; c < 6; c++) begin
            if (!pv[0]) begin
                pv[0] = 1;
                pd[0] = $urandom;
            end
            cycle();
        end
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            if (rst) for (int i = 0; i < N; i++) pv[i] = 0;
            iss_valid = 1'($urandom_range(0, 1));
            iss_rd = AW'($urandom_range(0, 7));
            chk_raddr1 = AW'($urandom_range(0, 7));
            chk_raddr2 = AW'($urandom_range(0, 7));
            for (int i = 0; i < N; i++) begin
                if (!rst && !pv[i] && $urandom_range(0, 1) == 1) begin
                    pv[i] = 1;
                    pa[i] = AW'($urandom_range(0, 7));
                    pd[i] = $urandom;
                end
            end
            cycle();
            if (n % 50 == 0) probe();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
